voice_mix_sched: RTL
====================

# voice_mix_sched

Time-multiplexed mix scheduler sharing one instance of the existing 18-bit two-input `mixer` across NVOICES voice generators. On each audio sample tick it fetches each enabled voice sample over a request/acknowledge handshake and folds it into a running accumulator through the mixer: acc = mix(acc, voice[i]). It sits between the voice generator bank and the DAC/output serializer, and publishes one mixed 18-bit sample per tick.

## Interface
- NVOICES, 8: number of voices (2..16).
- IDXW, $clog2(NVOICES): voice index width.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle pulse that starts a mix pass.
- voice_en  in  NVOICES  per-voice enable; sampled once, at tick acceptance.
- voice_req  out  1  request for the sample of voice `voice_idx`.
- voice_idx  out  IDXW  voice being fetched.
- voice_ack  in  1  sample valid; may be asserted combinationally in the same cycle as `voice_req`.
- voice_sample  in  18  offset-binary voice sample, captured when voice_req && voice_ack.
- mix_out  out  18  last completed mix; held between passes.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- busy  out  1  high whenever the state is not IDLE.
- overrun  out  1  sticky; set when a tick is dropped.
- overrun_clr  in  1  clears overrun; a set in the same cycle wins.

## Operation
- Mixer function, mod 2^18: Z = 2A + 2B − floor(A·B / 2^17) − 2^18. 0x20000 is neutral: mix(x, 0x20000) = x.
- States: IDLE, FETCH, MIX1, MIX2, STORE, DONE.
- IDLE, sample_tick=1:
  - acc ← 0x20000
  - en_q ← voice_en
  - idx ← 0
  - next state FETCH.
- FETCH, en_q[idx]=0: no request is issued. Advance to the next voice after 1 cycle, or go to DONE if idx = NVOICES−1.
- FETCH, en_q[idx]=1:
  - Assert voice_req with voice_idx=idx.
  - Hold the request until voice_ack; there is no timeout.
  - On ack: op_b ← voice_sample, next state MIX1.
- Mixer operands: A=acc, B=op_b, both held stable from MIX1 through STORE.
- MIX1 and MIX2 each last one cycle and cover the mixer pipeline.
- STORE:
  - acc ← Z
  - If idx = NVOICES−1, go to DONE; otherwise idx+1 and go to FETCH.
- DONE: mix_out ← acc, mix_valid=1 for this cycle, next state IDLE.
- A sample_tick seen in any state other than IDLE is ignored and sets overrun.
- When all voices are disabled, mix_out becomes 0x20000.
- Reset values (asynchronous, any state):
  - state IDLE
  - mix_out 0x20000, mix_valid 0, voice_req 0, voice_idx 0
  - busy 0, overrun 0, acc 0x20000.
- Reset mid-pass aborts the pass: no mix_valid, and mix_out returns to 0x20000.

## Timing
- Accepted tick at cycle t: FETCH of voice 0 starts at t+1.
- Enabled voice with same-cycle ack: 4 cycles (FETCH, MIX1, MIX2, STORE).
- Each extra wait cycle before ack adds 1 cycle.
- Disabled voice: 1 cycle.
- Pass length with all voices enabled and immediate acks: 4·NVOICES + 1 cycles from tick to mix_valid, counting DONE. For NVOICES=8 that is 33 cycles.
- Tick period must exceed this length to avoid overrun.
- voice_idx changes only on FETCH entry.
- voice_req is registered-state-decoded: no glitch path from voice_ack.
- mix_out is stable except in the DONE cycle.

## Structure
- Shared package `synth_pkg`:
  - SAMPLE_W = 18
  - SILENCE = 18'h20000
  - state enum.
- One sub-module: the existing `mixer` (clk, A, B, Z), instantiated unchanged.
- The mixer has no reset; the scheduler guarantees operand stability across MIX1..STORE, so stale pipeline contents after reset are never sampled.
- The scheduler core is an FSM plus idx counter, acc/op_b registers, and the overrun flag.

## Test plan
- NVOICES=4, all enabled, every sample 0x20000, immediate acks → mix_valid at tick+17, mix_out=0x20000.
- Voice 1 = 0x30000, others 0x20000 → mix_out=0x30000.
- Voices 0 and 2 = 0x30000, others 0x20000 → mix_out=0x38000.
- voice_en=4'b0000 → no voice_req; mix_valid at tick+5 with mix_out=0x20000.
- voice_ack delayed 3 cycles on voice 2 → voice_req held with voice_idx=2; mix_valid at tick+20; result unchanged.
- Second tick at tick+5 → overrun=1 and the pass completes normally.
- overrun_clr in a later cycle → overrun=0.
- rst_n low during MIX2 → outputs return to reset values immediately.
- The next tick after reset release produces a correct pass.

Source files
------------

// File: rtl/voice_mix_sched_pkg.sv
// Shared definitions for the voice mix scheduler: sample width, the silence
// level that is the mixer's neutral operand, and the scheduler state encoding.
package synth_pkg;

  localparam int SAMPLE_W = 18;
  localparam logic [SAMPLE_W-1:0] SILENCE = 18'h20000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MIX1,
    ST_MIX2,
    ST_STORE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/voice_mix_sched_if.sv
// Voice fetch handshake between the mix scheduler (master) and the voice
// generator bank (slave). The slave may answer combinationally in the request cycle.
interface voice_if
  import synth_pkg::*;
#(
  parameter int NVOICES = 8,
  parameter int IDXW    = $clog2(NVOICES)
);

  logic                voice_req;
  logic [IDXW-1:0]     voice_idx;
  logic                voice_ack;
  logic [SAMPLE_W-1:0] voice_sample;

  modport master (
    output voice_req,
    output voice_idx,
    input  voice_ack,
    input  voice_sample
  );

  modport slave (
    input  voice_req,
    input  voice_idx,
    output voice_ack,
    output voice_sample
  );

endinterface

// File: rtl/voice_mix_sched_mixer.sv
// Two-input offset-binary mixer, two register stages, no reset.
// Z = 2A + 2B - floor(A*B / 2^(DATA_W-1)) - 2^DATA_W, all mod 2^DATA_W.
module mixer #(
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Z
);

  // The -2^DATA_W term vanishes modulo 2^DATA_W, so only three terms remain.
  function automatic logic [DATA_W-1:0] mix_fn(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] a2;
    logic [DATA_W-1:0] b2;
    logic [DATA_W-1:0] prod_hi;
    a2      = {a[DATA_W-2:0], 1'b0};
    b2      = {b[DATA_W-2:0], 1'b0};
    prod_hi = DATA_W'(((2*DATA_W)'(a) * (2*DATA_W)'(b)) >> (DATA_W - 1));
    return a2 + b2 - prod_hi;
  endfunction

  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  logic [DATA_W-1:0] z_p1;

  // Stage p0: operand capture
  always_ff @(posedge clk) begin
    a_p0 <= A;
    b_p0 <= B;
  end

  // Stage p1: mix result
  always_ff @(posedge clk) begin
    z_p1 <= mix_fn(a_p0, b_p0);
  end

  assign Z = z_p1;

endmodule

// File: rtl/voice_mix_sched.sv
// Time-multiplexed mix scheduler: on each sample tick, folds every enabled voice
// into a running accumulator through one shared mixer and publishes the result.
module voice_mix_sched
  import synth_pkg::*;
#(
  parameter int NVOICES = 8,
  parameter int IDXW    = $clog2(NVOICES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic [NVOICES-1:0]  voice_en,
  voice_if.master             vif,
  output logic [SAMPLE_W-1:0] mix_out,
  output logic                mix_valid,
  output logic                busy,
  output logic                overrun,
  input  logic                overrun_clr
);

  state_t              state;
  logic [NVOICES-1:0]  en_q;
  logic [IDXW-1:0]     idx;
  logic [IDXW-1:0]     idx_nxt;
  logic                last;
  logic                req_q;
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W-1:0] op_b;
  logic [SAMPLE_W-1:0] mix_z;
  logic                take;

  assign idx_nxt = idx + 1'b1;
  assign last    = (idx == IDXW'(NVOICES - 1));
  assign take    = (state == ST_FETCH) && en_q[idx] && vif.voice_ack;

  assign vif.voice_req = req_q;
  assign vif.voice_idx = idx;

  // acc and op_b stay put from MIX1 through STORE, so Z in STORE reflects them.
  mixer #(.DATA_W(SAMPLE_W)) u_mixer (
    .clk (clk),
    .A   (acc),
    .B   (op_b),
    .Z   (mix_z)
  );

  always_ff @(posedge clk) begin
    if (take) op_b <= vif.voice_sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      en_q      <= '0;
      idx       <= '0;
      req_q     <= 1'b0;
      acc       <= SILENCE;
      mix_out   <= SILENCE;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (sample_tick && (state != ST_IDLE)) overrun <= 1'b1;
      else if (overrun_clr)                  overrun <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (sample_tick) begin
            acc   <= SILENCE;
            en_q  <= voice_en;
            idx   <= '0;
            req_q <= voice_en[0];
            busy  <= 1'b1;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (!en_q[idx]) begin
            if (last) begin
              mix_out   <= acc;
              mix_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              idx   <= idx_nxt;
              req_q <= en_q[idx_nxt];
            end
          end else if (vif.voice_ack) begin
            req_q <= 1'b0;
            state <= ST_MIX1;
          end
        end
        ST_MIX1: state <= ST_MIX2;
        ST_MIX2: state <= ST_STORE;
        ST_STORE: begin
          acc <= mix_z;
          if (last) begin
            mix_out   <= mix_z;
            mix_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            idx   <= idx_nxt;
            req_q <= en_q[idx_nxt];
            state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
